// File: rtl/mc_ctrl_if.sv
// Purpose: control/status bundle between the multicycle main controller and
//          the MIPS datapath.
// Signals:
//   opcode, alu_zero, mem_ready        datapath -> controller (IR[31:26], ALU zero, memory done)
//   pc_en, pc_src, iord                PC update and memory address select
//   mem_read, mem_write, ir_write      memory requests and IR load
//   reg_dst, mem_to_reg, reg_write     register file writeback controls
//   alu_src_a, alu_src_b, alu_op       ALU operand selects and ALU-control opcode
//   instr_done, retired, illegal       instruction status and retired count
// Modports: master = controller side, slave = datapath side.
interface mc_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [5:0]       opcode;
  logic             alu_zero;
  logic             mem_ready;
  logic             pc_en;
  logic [1:0]       pc_src;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             instr_done;
  logic [CNT_W-1:0] retired;
  logic             illegal;

  modport master (
    input  opcode, alu_zero, mem_ready,
    output pc_en, pc_src, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           instr_done, retired, illegal
  );

  modport slave (
    output opcode, alu_zero, mem_ready,
    input  pc_en, pc_src, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           instr_done, retired, illegal
  );
endinterface

// File: rtl/mc_ctrl.sv
// Purpose: multicycle main controller for the MIPS subset datapath. Sequences
//          FETCH/DECODE/EXEC/MEM/WB phases over a shared ALU, a unified memory
//          port with ready handshake, and the register file.
// Ports:
//   clk    rising-edge system clock
//   rst_n  asynchronous active-low reset (state -> IDLE, retired -> 0)
//   bus    mc_ctrl_if.master: opcode/alu_zero/mem_ready in, all controls out
// Build option: ILLEGAL_TRAP_EN - unlisted opcodes enter a TRAP state that
//   raises illegal until reset; otherwise they retire as a NOP.
module mc_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  mc_ctrl_if.master bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB,
    S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP
`ifdef ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  // State-only (Moore) part of the control word, registered alongside the state
  typedef struct packed {
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       done;
    logic       jump;
  } moore_t;

  state_t           r_state;
  state_t           w_next;
  moore_t           r_mo;
  logic [CNT_W-1:0] r_retired;
  logic             w_fetch_go;
  logic             w_nop;
  logic             w_instr_done;

  // Control word for a given state
  function automatic moore_t moore(input state_t s);
    moore_t m;
    m = '0;
    case (s)
      S_FETCH:    begin m.mem_read = 1'b1; m.alu_src_b = 2'b01; end
      S_DECODE:   m.alu_src_b = 2'b11;
      S_R_EXEC:   begin m.alu_src_a = 1'b1; m.alu_op = 2'b10; end
      S_R_WB:     begin m.reg_dst = 1'b1; m.reg_write = 1'b1; m.done = 1'b1; end
      S_I_EXEC:   begin m.alu_src_a = 1'b1; m.alu_src_b = 2'b10; m.alu_op = 2'b11; end
      S_I_WB:     begin m.reg_write = 1'b1; m.done = 1'b1; end
      S_MEM_ADDR: begin m.alu_src_a = 1'b1; m.alu_src_b = 2'b10; end
      S_MEM_RD:   begin m.mem_read = 1'b1; m.iord = 1'b1; end
      S_MEM_WB:   begin m.mem_to_reg = 1'b1; m.reg_write = 1'b1; m.done = 1'b1; end
      S_MEM_WR:   begin m.mem_write = 1'b1; m.iord = 1'b1; end
      S_BRANCH:   begin
        m.alu_src_a = 1'b1; m.alu_op = 2'b01; m.pc_src = 2'b01; m.done = 1'b1;
      end
      S_JUMP:     begin m.pc_src = 2'b10; m.jump = 1'b1; m.done = 1'b1; end
      default:    m = '0;
    endcase
    return m;
  endfunction

  function automatic logic known_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_BNE) || (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_J);
  endfunction

  // Next-state logic; opcode only matters in DECODE and MEM_ADDR
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     w_next = S_FETCH;
      S_FETCH:    if (bus.mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:       w_next = S_R_EXEC;
          OP_LW, OP_SW:   w_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE: w_next = S_BRANCH;
          OP_ADDI, OP_ANDI: w_next = S_I_EXEC;
          OP_J:           w_next = S_JUMP;
`ifdef ILLEGAL_TRAP_EN
          default:        w_next = S_TRAP;
`else
          default:        w_next = S_FETCH;
`endif
        endcase
      end
      S_R_EXEC:   w_next = S_R_WB;
      S_I_EXEC:   w_next = S_I_WB;
      S_MEM_ADDR: w_next = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (bus.mem_ready) w_next = S_MEM_WB;
      S_MEM_WR:   if (bus.mem_ready) w_next = S_FETCH;
      S_R_WB, S_I_WB, S_MEM_WB, S_BRANCH, S_JUMP: w_next = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:     w_next = S_TRAP;
`endif
      default:    w_next = S_IDLE;
    endcase
  end

  // Handshake-dependent terms that must react within the same cycle
  assign w_fetch_go = (r_state == S_FETCH) && bus.mem_ready;
`ifdef ILLEGAL_TRAP_EN
  assign w_nop = 1'b0;
`else
  assign w_nop = (r_state == S_DECODE) && !known_op(bus.opcode);
`endif
  assign w_instr_done = r_mo.done || w_nop || ((r_state == S_MEM_WR) && bus.mem_ready);

  // State, registered control word and retired counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_mo      <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      r_mo    <= moore(w_next);
      if (w_instr_done) r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign bus.pc_en      = w_fetch_go || ((r_state == S_BRANCH) && bus.alu_zero) || r_mo.jump;
  assign bus.ir_write   = w_fetch_go;
  assign bus.pc_src     = r_mo.pc_src;
  assign bus.iord       = r_mo.iord;
  assign bus.mem_read   = r_mo.mem_read;
  assign bus.mem_write  = r_mo.mem_write;
  assign bus.reg_dst    = r_mo.reg_dst;
  assign bus.mem_to_reg = r_mo.mem_to_reg;
  assign bus.reg_write  = r_mo.reg_write;
  assign bus.alu_src_a  = r_mo.alu_src_a;
  assign bus.alu_src_b  = r_mo.alu_src_b;
  assign bus.alu_op     = r_mo.alu_op;
  assign bus.instr_done = w_instr_done;
  assign bus.retired    = r_retired;
`ifdef ILLEGAL_TRAP_EN
  assign bus.illegal    = (r_state == S_TRAP);
`else
  assign bus.illegal    = 1'b0;
`endif

endmodule
